// File: rtl/parametrik_buyruk_onbellegi.sv
// Direct-mapped instruction cache with zero-latency hit path, word-by-word
// line refill over a valid/ready memory port, fence.i flush and hit/miss counters.
module parametrik_buyruk_onbellegi #(
  parameter int ADRES_W      = 32,
  parameter int SATIR_SAYISI = 64,
  parameter int SATIR_KELIME = 4,
  parameter int SAYAC_W      = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,

  input  logic [ADRES_W-1:0] l1b_adres_i,
  output logic [31:0]        l1b_deger_o,
  output logic               l1b_bekle_o,
  input  logic               l1b_gecersiz_i,

  output logic               iomem_valid,
  input  logic               iomem_ready,
  output logic [ADRES_W-1:0] iomem_addr,
  input  logic [31:0]        iomem_rdata,

  output logic [SAYAC_W-1:0] isabet_sayisi_o,
  output logic [SAYAC_W-1:0] iskalama_sayisi_o
);

  localparam int KELIME_W = $clog2(SATIR_KELIME);
  localparam int OFS_W    = KELIME_W + 2;
  localparam int IDX_W    = $clog2(SATIR_SAYISI);
  localparam int TAG_W    = ADRES_W - OFS_W - IDX_W;
  localparam int SAY_W    = (KELIME_W > 0) ? KELIME_W : 1;
  localparam logic [ADRES_W-1:0] OFS_MASKE = ADRES_W'((64'd1 << OFS_W) - 64'd1);

  typedef enum logic [1:0] {
    LOOKUP,
    REFILL,
    FLUSH
  } durum_t;

  durum_t r_durum;
  durum_t w_sonraki;

  logic [SATIR_SAYISI-1:0] r_gecerli;
  logic [TAG_W-1:0]        r_etiket [SATIR_SAYISI];
  logic [31:0]             r_veri   [SATIR_SAYISI][SATIR_KELIME];

  logic [ADRES_W-1:0] r_taban;
  logic [SAY_W-1:0]   r_sayac;
  logic               r_bekleyen;
  logic [SAYAC_W-1:0] r_isabet;
  logic [SAYAC_W-1:0] r_iskalama;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [SAY_W-1:0] w_kelime_sec;
  logic [IDX_W-1:0] w_ref_idx;
  logic [TAG_W-1:0] w_ref_tag;
  logic             w_isabet;
  logic             w_kabul;
  logic             w_son_kelime;
  logic             w_iskalama_bas;
  logic             w_isabet_say;

  // Fetch-side address decode.
  assign w_idx = l1b_adres_i[OFS_W+IDX_W-1:OFS_W];
  assign w_tag = l1b_adres_i[ADRES_W-1:OFS_W+IDX_W];

  generate
    if (KELIME_W > 0) begin : g_kelime_sec
      assign w_kelime_sec = l1b_adres_i[OFS_W-1:2];
    end else begin : g_tek_kelime
      assign w_kelime_sec = '0;
    end
  endgenerate

  // Refill side works only from the latched base, never from the live fetch address.
  assign w_ref_idx    = r_taban[OFS_W+IDX_W-1:OFS_W];
  assign w_ref_tag    = r_taban[ADRES_W-1:OFS_W+IDX_W];
  assign iomem_addr   = r_taban + (ADRES_W'(r_sayac) << 2);
  assign w_son_kelime = (r_sayac == SAY_W'(SATIR_KELIME - 1));
  assign w_kabul      = (r_durum == REFILL) && iomem_ready;

  assign w_isabet    = r_gecerli[w_idx] && (r_etiket[w_idx] == w_tag);
  assign l1b_deger_o = r_veri[w_idx][w_kelime_sec];

  assign isabet_sayisi_o   = r_isabet;
  assign iskalama_sayisi_o = r_iskalama;

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_sonraki      = r_durum;
    l1b_bekle_o    = 1'b1;
    iomem_valid    = 1'b0;
    w_iskalama_bas = 1'b0;
    w_isabet_say   = 1'b0;
    case (r_durum)
      LOOKUP: begin
        l1b_bekle_o  = !w_isabet;
        w_isabet_say = w_isabet;
        if (l1b_gecersiz_i) begin
          w_sonraki = FLUSH;
        end else if (!w_isabet) begin
          w_sonraki      = REFILL;
          w_iskalama_bas = 1'b1;
        end
      end
      REFILL: begin
        iomem_valid = 1'b1;
        if (iomem_ready && w_son_kelime) begin
          w_sonraki = (r_bekleyen || l1b_gecersiz_i) ? FLUSH : LOOKUP;
        end
      end
      FLUSH: begin
        w_sonraki = LOOKUP;
      end
      default: begin
        w_sonraki = LOOKUP;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_durum    <= LOOKUP;
      r_gecerli  <= '0;
      r_taban    <= '0;
      r_sayac    <= '0;
      r_bekleyen <= 1'b0;
      r_isabet   <= '0;
      r_iskalama <= '0;
    end else begin
      r_durum <= w_sonraki;

      if (w_iskalama_bas) begin
        r_taban <= l1b_adres_i & ~OFS_MASKE;
        r_sayac <= '0;
      end

      if (w_kabul) begin
        r_sayac <= r_sayac + 1'b1;
        if (w_son_kelime) begin
          r_gecerli[w_ref_idx] <= 1'b1;
        end
      end

      // A fence.i arriving mid-refill is remembered and served once the line is in.
      if ((r_durum == REFILL) && l1b_gecersiz_i) begin
        r_bekleyen <= 1'b1;
      end

      if (r_durum == FLUSH) begin
        r_gecerli  <= '0;
        r_bekleyen <= 1'b0;
      end

      if (w_isabet_say && (r_isabet != '1)) begin
        r_isabet <= r_isabet + 1'b1;
      end
      if (w_iskalama_bas && (r_iskalama != '1)) begin
        r_iskalama <= r_iskalama + 1'b1;
      end
    end
  end

  // NOTE: data and tag arrays carry no reset; the valid bits alone decide
  // whether their contents are ever used, and resetting a RAM is not possible.
  always_ff @(posedge clk_i) begin
    if (w_kabul) begin
      r_veri[w_ref_idx][r_sayac] <= iomem_rdata;
      if (w_son_kelime) begin
        r_etiket[w_ref_idx] <= w_ref_tag;
      end
    end
  end

endmodule

// File: tb/tb_parametrik_buyruk_onbellegi.sv
// Directed bench for the instruction cache: cold miss, hits, conflict,
// backpressure, flush during refill and in lookup, reset during refill.
module tb_parametrik_buyruk_onbellegi;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [31:0] l1b_adres_i = '0;
  logic [31:0] l1b_deger_o;
  logic        l1b_bekle_o;
  logic        l1b_gecersiz_i = 1'b0;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_rdata = '0;
  logic [31:0] isabet_sayisi_o;
  logic [31:0] iskalama_sayisi_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] got_addr [4];
  bit          stable_ok;

  parametrik_buyruk_onbellegi #(
    .ADRES_W(32), .SATIR_SAYISI(64), .SATIR_KELIME(4), .SAYAC_W(32)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .l1b_adres_i      (l1b_adres_i),
    .l1b_deger_o      (l1b_deger_o),
    .l1b_bekle_o      (l1b_bekle_o),
    .l1b_gecersiz_i   (l1b_gecersiz_i),
    .iomem_valid      (iomem_valid),
    .iomem_ready      (iomem_ready),
    .iomem_addr       (iomem_addr),
    .iomem_rdata      (iomem_rdata),
    .isabet_sayisi_o  (isabet_sayisi_o),
    .iskalama_sayisi_o(iskalama_sayisi_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h1000: return 32'h11;
      32'h1004: return 32'h22;
      32'h1008: return 32'h33;
      32'h100C: return 32'h44;
      default:  return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  // Memory responder: serves n beats, holding ready low wt cycles before each,
  // optionally pulsing the flush request together with beat fb.
  task automatic serve(input int n, input int wt, input int fb);
    int          c;
    logic [31:0] a;
    stable_ok = 1'b1;
    for (int i = 0; i < 4; i++) got_addr[i] = 'x;
    for (int b = 0; b < n; b++) begin
      c = 0;
      while (iomem_valid !== 1'b1 && c < 50) begin
        tick();
        c++;
      end
      if (iomem_valid !== 1'b1) return;
      a = iomem_addr;
      for (int w = 0; w < wt; w++) begin
        tick();
        if (iomem_valid !== 1'b1 || iomem_addr !== a || l1b_bekle_o !== 1'b1) stable_ok = 1'b0;
      end
      got_addr[b]  = a;
      iomem_rdata  = mem_word(a);
      iomem_ready  = 1'b1;
      if (b == fb) l1b_gecersiz_i = 1'b1;
      tick();
      iomem_ready    = 1'b0;
      l1b_gecersiz_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    l1b_adres_i = 32'h0000_1008;
    rst_ni = 1'b0;
    repeat (3) tick();
    n_tests++; if (iomem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", iomem_valid); end
    n_tests++; if (isabet_sayisi_o !== 32'd0) begin n_fail++; $display("FAIL reset_isabet: got %0d expected 0", isabet_sayisi_o); end
    n_tests++; if (iskalama_sayisi_o !== 32'd0) begin n_fail++; $display("FAIL reset_iskalama: got %0d expected 0", iskalama_sayisi_o); end
    n_tests++; if (l1b_bekle_o !== 1'b1) begin n_fail++; $display("FAIL reset_bekle: got %b expected 1", l1b_bekle_o); end
    rst_ni = 1'b1;
    #1;
    n_tests++; if (l1b_bekle_o !== 1'b1) begin n_fail++; $display("FAIL release_bekle: got %b expected 1", l1b_bekle_o); end
    n_tests++; if (iomem_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b expected 0", iomem_valid); end
  endtask

  task automatic test_cold_miss();
    serve(4, 0, -1);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (got_addr[i] !== 32'h1000 + 32'(4 * i)) begin n_fail++; $display("FAIL cold_addr%0d: got %h expected %h", i, got_addr[i], 32'h1000 + 32'(4 * i)); end
    end
    n_tests++; if (l1b_bekle_o !== 1'b0) begin n_fail++; $display("FAIL cold_bekle: got %b expected 0", l1b_bekle_o); end
    n_tests++; if (l1b_deger_o !== 32'h33) begin n_fail++; $display("FAIL cold_deger: got %h expected 33", l1b_deger_o); end
    n_tests++; if (iskalama_sayisi_o !== 32'd1) begin n_fail++; $display("FAIL cold_iskalama: got %0d expected 1", iskalama_sayisi_o); end
    n_tests++; if (isabet_sayisi_o !== 32'd0) begin n_fail++; $display("FAIL cold_isabet: got %0d expected 0", isabet_sayisi_o); end
  endtask

  task automatic test_hit();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin
      l1b_adres_i = 32'h1000 + 32'(4 * i);
      #1;
      n_tests++; if (l1b_bekle_o !== 1'b0) begin n_fail++; $display("FAIL hit%0d_bekle: got %b expected 0", i, l1b_bekle_o); end
      n_tests++; if (l1b_deger_o !== exp_d[i]) begin n_fail++; $display("FAIL hit%0d_deger: got %h expected %h", i, l1b_deger_o, exp_d[i]); end
      n_tests++; if (iomem_valid !== 1'b0) begin n_fail++; $display("FAIL hit%0d_valid: got %b expected 0", i, iomem_valid); end
      tick();
    end
    n_tests++; if (isabet_sayisi_o !== 32'd4) begin n_fail++; $display("FAIL hit_isabet: got %0d expected 4", isabet_sayisi_o); end
    n_tests++; if (iskalama_sayisi_o !== 32'd1) begin n_fail++; $display("FAIL hit_iskalama: got %0d expected 1", iskalama_sayisi_o); end
  endtask

  task automatic test_conflict();
    l1b_adres_i = 32'h0000_1408;
    #1;
    n_tests++; if (l1b_bekle_o !== 1'b1) begin n_fail++; $display("FAIL conf_bekle: got %b expected 1", l1b_bekle_o); end
    serve(4, 0, -1);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (got_addr[i] !== 32'h1400 + 32'(4 * i)) begin n_fail++; $display("FAIL conf_addr%0d: got %h expected %h", i, got_addr[i], 32'h1400 + 32'(4 * i)); end
    end
    n_tests++; if (l1b_deger_o !== 32'hC0DE_1408) begin n_fail++; $display("FAIL conf_deger: got %h expected c0de1408", l1b_deger_o); end
    n_tests++; if (iskalama_sayisi_o !== 32'd2) begin n_fail++; $display("FAIL conf_iskalama: got %0d expected 2", iskalama_sayisi_o); end
    l1b_adres_i = 32'h0000_1008;
    #1;
    n_tests++; if (l1b_bekle_o !== 1'b1) begin n_fail++; $display("FAIL conf_remiss: got %b expected 1", l1b_bekle_o); end
    serve(4, 0, -1);
    n_tests++; if (got_addr[0] !== 32'h1000) begin n_fail++; $display("FAIL conf_readdr: got %h expected 1000", got_addr[0]); end
    n_tests++; if (l1b_deger_o !== 32'h33) begin n_fail++; $display("FAIL conf_redeger: got %h expected 33", l1b_deger_o); end
    n_tests++; if (iskalama_sayisi_o !== 32'd3) begin n_fail++; $display("FAIL conf_reiskalama: got %0d expected 3", iskalama_sayisi_o); end
    n_tests++; if (isabet_sayisi_o !== 32'd4) begin n_fail++; $display("FAIL conf_isabet: got %0d expected 4", isabet_sayisi_o); end
  endtask

  task automatic test_backpressure();
    l1b_adres_i = 32'h0000_2008;
    serve(4, 0, -1);
    n_tests++; if (l1b_deger_o !== 32'hC0DE_2008) begin n_fail++; $display("FAIL bp_evict_deger: got %h expected c0de2008", l1b_deger_o); end
    l1b_adres_i = 32'h0000_1008;
    serve(4, 5, -1);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (got_addr[i] !== 32'h1000 + 32'(4 * i)) begin n_fail++; $display("FAIL bp_addr%0d: got %h expected %h", i, got_addr[i], 32'h1000 + 32'(4 * i)); end
    end
    n_tests++; if (stable_ok !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %b expected 1", stable_ok); end
    n_tests++; if (l1b_bekle_o !== 1'b0) begin n_fail++; $display("FAIL bp_bekle: got %b expected 0", l1b_bekle_o); end
    n_tests++; if (l1b_deger_o !== 32'h33) begin n_fail++; $display("FAIL bp_deger: got %h expected 33", l1b_deger_o); end
    n_tests++; if (iskalama_sayisi_o !== 32'd5) begin n_fail++; $display("FAIL bp_iskalama: got %0d expected 5", iskalama_sayisi_o); end
  endtask

  task automatic test_flush_mid_refill();
    l1b_adres_i = 32'h0000_1408;
    serve(4, 0, -1);
    l1b_adres_i = 32'h0000_1008;
    serve(4, 0, 1);
    n_tests++; if (got_addr[3] !== 32'h100C) begin n_fail++; $display("FAIL fmr_beats: got %h expected 100c", got_addr[3]); end
    n_tests++; if (l1b_bekle_o !== 1'b1) begin n_fail++; $display("FAIL fmr_flush_bekle: got %b expected 1", l1b_bekle_o); end
    n_tests++; if (iomem_valid !== 1'b0) begin n_fail++; $display("FAIL fmr_flush_valid: got %b expected 0", iomem_valid); end
    n_tests++; if (iskalama_sayisi_o !== 32'd7) begin n_fail++; $display("FAIL fmr_iskalama: got %0d expected 7", iskalama_sayisi_o); end
    tick();
    n_tests++; if (l1b_bekle_o !== 1'b1) begin n_fail++; $display("FAIL fmr_lookup_bekle: got %b expected 1", l1b_bekle_o); end
    tick();
    n_tests++; if (iomem_valid !== 1'b1 || iomem_addr !== 32'h1000) begin n_fail++; $display("FAIL fmr_remiss: got valid=%b addr=%h expected valid=1 addr=1000", iomem_valid, iomem_addr); end
    n_tests++; if (iskalama_sayisi_o !== 32'd8) begin n_fail++; $display("FAIL fmr_reiskalama: got %0d expected 8", iskalama_sayisi_o); end
    serve(4, 0, -1);
    n_tests++; if (l1b_bekle_o !== 1'b0 || l1b_deger_o !== 32'h33) begin n_fail++; $display("FAIL fmr_refill: got bekle=%b deger=%h expected bekle=0 deger=33", l1b_bekle_o, l1b_deger_o); end
    n_tests++; if (isabet_sayisi_o !== 32'd4) begin n_fail++; $display("FAIL fmr_isabet: got %0d expected 4", isabet_sayisi_o); end
  endtask

  task automatic test_flush_lookup();
    l1b_gecersiz_i = 1'b1;
    #1;
    n_tests++; if (l1b_bekle_o !== 1'b0) begin n_fail++; $display("FAIL fl_hit_bekle: got %b expected 0", l1b_bekle_o); end
    tick();
    l1b_gecersiz_i = 1'b0;
    n_tests++; if (l1b_bekle_o !== 1'b1 || iomem_valid !== 1'b0) begin n_fail++; $display("FAIL fl_flush: got bekle=%b valid=%b expected bekle=1 valid=0", l1b_bekle_o, iomem_valid); end
    n_tests++; if (isabet_sayisi_o !== 32'd5) begin n_fail++; $display("FAIL fl_isabet: got %0d expected 5", isabet_sayisi_o); end
    tick();
    n_tests++; if (l1b_bekle_o !== 1'b1) begin n_fail++; $display("FAIL fl_invalid: got %b expected 1", l1b_bekle_o); end
    l1b_gecersiz_i = 1'b1;
    tick();
    l1b_gecersiz_i = 1'b0;
    n_tests++; if (iomem_valid !== 1'b0) begin n_fail++; $display("FAIL fl_prio_valid: got %b expected 0", iomem_valid); end
    n_tests++; if (iskalama_sayisi_o !== 32'd8) begin n_fail++; $display("FAIL fl_prio_iskalama: got %0d expected 8", iskalama_sayisi_o); end
    tick();
    n_tests++; if (iomem_valid !== 1'b0 || l1b_bekle_o !== 1'b1) begin n_fail++; $display("FAIL fl_back_lookup: got valid=%b bekle=%b expected valid=0 bekle=1", iomem_valid, l1b_bekle_o); end
    serve(4, 0, -1);
    n_tests++; if (iskalama_sayisi_o !== 32'd9) begin n_fail++; $display("FAIL fl_iskalama: got %0d expected 9", iskalama_sayisi_o); end
    n_tests++; if (l1b_deger_o !== 32'h33) begin n_fail++; $display("FAIL fl_deger: got %h expected 33", l1b_deger_o); end
  endtask

  task automatic test_reset_mid_refill();
    l1b_adres_i = 32'h0000_1408;
    serve(4, 0, -1);
    l1b_adres_i = 32'h0000_1008;
    serve(2, 0, -1);
    n_tests++; if (got_addr[1] !== 32'h1004) begin n_fail++; $display("FAIL rmr_partial: got %h expected 1004", got_addr[1]); end
    rst_ni = 1'b0;
    #1;
    n_tests++; if (iomem_valid !== 1'b0) begin n_fail++; $display("FAIL rmr_valid: got %b expected 0", iomem_valid); end
    n_tests++; if (isabet_sayisi_o !== 32'd0 || iskalama_sayisi_o !== 32'd0) begin n_fail++; $display("FAIL rmr_counters: got %0d/%0d expected 0/0", isabet_sayisi_o, iskalama_sayisi_o); end
    tick();
    rst_ni = 1'b1;
    #1;
    n_tests++; if (l1b_bekle_o !== 1'b1) begin n_fail++; $display("FAIL rmr_bekle: got %b expected 1", l1b_bekle_o); end
    serve(4, 0, -1);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (got_addr[i] !== 32'h1000 + 32'(4 * i)) begin n_fail++; $display("FAIL rmr_addr%0d: got %h expected %h", i, got_addr[i], 32'h1000 + 32'(4 * i)); end
    end
    n_tests++; if (l1b_bekle_o !== 1'b0 || l1b_deger_o !== 32'h33) begin n_fail++; $display("FAIL rmr_refill: got bekle=%b deger=%h expected bekle=0 deger=33", l1b_bekle_o, l1b_deger_o); end
    n_tests++; if (iskalama_sayisi_o !== 32'd1) begin n_fail++; $display("FAIL rmr_iskalama: got %0d expected 1", iskalama_sayisi_o); end
  endtask

  initial begin
    tick();
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_backpressure();
    test_flush_mid_refill();
    test_flush_lookup();
    test_reset_mid_refill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
